// File: rtl/tlb_sweep.sv
// Parametrised MIPS-style TLB: multi-port registered search, direct/random writes,
// a decrementing replacement index and a one-entry-per-cycle flush engine.
module tlb_sweep #(
  parameter int TLBNUM = 16,
  parameter int NSPORT = 2,
  localparam int IDXW = $clog2(TLBNUM)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NSPORT*19-1:0]     s_vpn2,
  input  logic [NSPORT-1:0]        s_odd_page,
  input  logic [NSPORT*8-1:0]      s_asid,
  output logic [NSPORT-1:0]        s_found,
  output logic [NSPORT-1:0]        s_multi,
  output logic [NSPORT*IDXW-1:0]   s_index,
  output logic [NSPORT*20-1:0]     s_pfn,
  output logic [NSPORT*3-1:0]      s_c,
  output logic [NSPORT-1:0]        s_d,
  output logic [NSPORT-1:0]        s_v,
  input  logic                     we,
  input  logic                     w_random,
  input  logic [IDXW-1:0]          w_index,
  input  logic [18:0]              w_vpn2,
  input  logic [7:0]               w_asid,
  input  logic                     w_g,
  input  logic [19:0]              w_pfn0,
  input  logic [2:0]               w_c0,
  input  logic                     w_d0,
  input  logic                     w_v0,
  input  logic [19:0]              w_pfn1,
  input  logic [2:0]               w_c1,
  input  logic                     w_d1,
  input  logic                     w_v1,
  input  logic [IDXW-1:0]          r_index,
  output logic                     r_e,
  output logic [18:0]              r_vpn2,
  output logic [7:0]               r_asid,
  output logic                     r_g,
  output logic [19:0]              r_pfn0,
  output logic [2:0]               r_c0,
  output logic                     r_d0,
  output logic                     r_v0,
  output logic [19:0]              r_pfn1,
  output logic [2:0]               r_c1,
  output logic                     r_d1,
  output logic                     r_v1,
  output logic [IDXW-1:0]          rand_index,
  input  logic                     flush_req,
  input  logic                     flush_mode,
  input  logic [7:0]               flush_asid,
  output logic                     flush_busy,
  output logic                     flush_done
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  logic [TLBNUM-1:0] tlb_e;
  logic [18:0]       tlb_vpn2 [TLBNUM];
  logic [7:0]        tlb_asid [TLBNUM];
  logic              tlb_g    [TLBNUM];
  logic [19:0]       tlb_pfn0 [TLBNUM];
  logic [2:0]        tlb_c0   [TLBNUM];
  logic              tlb_d0   [TLBNUM];
  logic              tlb_v0   [TLBNUM];
  logic [19:0]       tlb_pfn1 [TLBNUM];
  logic [2:0]        tlb_c1   [TLBNUM];
  logic              tlb_d1   [TLBNUM];
  logic              tlb_v1   [TLBNUM];

  state_t            state;
  logic [IDXW-1:0]   ptr;
  logic              mode_q;
  logic [7:0]        asid_q;

  logic              wr_en;
  logic [IDXW-1:0]   wr_idx;

  logic [NSPORT-1:0]      nxt_found;
  logic [NSPORT-1:0]      nxt_multi;
  logic [NSPORT*IDXW-1:0] nxt_index;
  logic [NSPORT*20-1:0]   nxt_pfn;
  logic [NSPORT*3-1:0]    nxt_c;
  logic [NSPORT-1:0]      nxt_d;
  logic [NSPORT-1:0]      nxt_v;

  assign wr_en  = we & ~flush_busy;
  assign wr_idx = w_random ? rand_index : w_index;

  // Lowest matching index wins; any further match only raises the multi flag.
  always_comb begin
    nxt_found = '0;
    nxt_multi = '0;
    nxt_index = '0;
    nxt_pfn   = '0;
    nxt_c     = '0;
    nxt_d     = '0;
    nxt_v     = '0;
    for (int unsigned k = 0; k < NSPORT; k++) begin
      logic            h;
      logic            mu;
      logic [IDXW-1:0] ix;
      h  = 1'b0;
      mu = 1'b0;
      ix = '0;
      for (int unsigned i = 0; i < TLBNUM; i++) begin
        if (tlb_e[i] && (tlb_vpn2[i] == s_vpn2[k*19 +: 19]) &&
            ((tlb_asid[i] == s_asid[k*8 +: 8]) || tlb_g[i])) begin
          if (h) mu = 1'b1;
          else   ix = IDXW'(i);
          h = 1'b1;
        end
      end
      nxt_found[k] = h;
      nxt_multi[k] = mu;
      if (h) begin
        nxt_index[k*IDXW +: IDXW] = ix;
        if (s_odd_page[k]) begin
          nxt_pfn[k*20 +: 20] = tlb_pfn1[ix];
          nxt_c[k*3 +: 3]     = tlb_c1[ix];
          nxt_d[k]            = tlb_d1[ix];
          nxt_v[k]            = tlb_v1[ix];
        end else begin
          nxt_pfn[k*20 +: 20] = tlb_pfn0[ix];
          nxt_c[k*3 +: 3]     = tlb_c0[ix];
          nxt_d[k]            = tlb_d0[ix];
          nxt_v[k]            = tlb_v0[ix];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_found <= '0;
      s_multi <= '0;
      s_index <= '0;
      s_pfn   <= '0;
      s_c     <= '0;
      s_d     <= '0;
      s_v     <= '0;
    end else begin
      s_found <= nxt_found;
      s_multi <= nxt_multi;
      s_index <= nxt_index;
      s_pfn   <= nxt_pfn;
      s_c     <= nxt_c;
      s_d     <= nxt_d;
      s_v     <= nxt_v;
    end
  end

  // Entry payload carries no reset; only the E bits define table validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tlb_vpn2[wr_idx] <= w_vpn2;
      tlb_asid[wr_idx] <= w_asid;
      tlb_g[wr_idx]    <= w_g;
      tlb_pfn0[wr_idx] <= w_pfn0;
      tlb_c0[wr_idx]   <= w_c0;
      tlb_d0[wr_idx]   <= w_d0;
      tlb_v0[wr_idx]   <= w_v0;
      tlb_pfn1[wr_idx] <= w_pfn1;
      tlb_c1[wr_idx]   <= w_c1;
      tlb_d1[wr_idx]   <= w_d1;
      tlb_v1[wr_idx]   <= w_v1;
    end
  end

  // Writes are blocked while sweeping, so a sweep clear never races a write set.
  always_ff @(posedge clk) begin
    if (reset) begin
      tlb_e      <= '0;
      state      <= IDLE;
      ptr        <= '0;
      mode_q     <= 1'b0;
      asid_q     <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
      rand_index <= IDXW'(TLBNUM - 1);
    end else begin
      rand_index <= rand_index - IDXW'(1);
      if (wr_en) tlb_e[wr_idx] <= 1'b1;
      case (state)
        SWEEP: begin
          if (!mode_q || ((tlb_asid[ptr] == asid_q) && !tlb_g[ptr]))
            tlb_e[ptr] <= 1'b0;
          ptr <= ptr + IDXW'(1);
          if (ptr == IDXW'(TLBNUM - 1)) begin
            state      <= DONE;
            flush_busy <= 1'b0;
            flush_done <= 1'b1;
          end
        end
        default: begin
          flush_done <= 1'b0;
          if (flush_req) begin
            mode_q     <= flush_mode;
            asid_q     <= flush_asid;
            ptr        <= '0;
            state      <= SWEEP;
            flush_busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign r_e    = tlb_e[r_index];
  assign r_vpn2 = tlb_vpn2[r_index];
  assign r_asid = tlb_asid[r_index];
  assign r_g    = tlb_g[r_index];
  assign r_pfn0 = tlb_pfn0[r_index];
  assign r_c0   = tlb_c0[r_index];
  assign r_d0   = tlb_d0[r_index];
  assign r_v0   = tlb_v0[r_index];
  assign r_pfn1 = tlb_pfn1[r_index];
  assign r_c1   = tlb_c1[r_index];
  assign r_d1   = tlb_d1[r_index];
  assign r_v1   = tlb_v1[r_index];

endmodule

// File: tb/tb_tlb_sweep.sv
// Directed bench for tlb_sweep: search results are scoreboarded one cycle ahead,
// table/flush state is checked against values derived in the bench.
module tb_tlb_sweep;
  localparam int TLBNUM = 16;
  localparam int NSPORT = 2;
  localparam int IDXW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [NSPORT*19-1:0]   s_vpn2;
  logic [NSPORT-1:0]      s_odd_page;
  logic [NSPORT*8-1:0]    s_asid;
  logic [NSPORT-1:0]      s_found, s_multi, s_d, s_v;
  logic [NSPORT*IDXW-1:0] s_index;
  logic [NSPORT*20-1:0]   s_pfn;
  logic [NSPORT*3-1:0]    s_c;
  logic                   we, w_random, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [IDXW-1:0]        w_index, r_index, rand_index;
  logic [18:0]            w_vpn2, r_vpn2;
  logic [7:0]             w_asid, r_asid, flush_asid;
  logic [19:0]            w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0]             w_c0, w_c1, r_c0, r_c1;
  logic                   r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic                   flush_req, flush_mode, flush_busy, flush_done;

  tlb_sweep #(.TLBNUM(TLBNUM), .NSPORT(NSPORT)) dut (
    .clk(clk), .reset(reset),
    .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
    .s_found(s_found), .s_multi(s_multi), .s_index(s_index), .s_pfn(s_pfn),
    .s_c(s_c), .s_d(s_d), .s_v(s_v),
    .we(we), .w_random(w_random), .w_index(w_index), .w_vpn2(w_vpn2),
    .w_asid(w_asid), .w_g(w_g), .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0),
    .w_v0(w_v0), .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_e(r_e), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0), .r_pfn1(r_pfn1),
    .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1), .rand_index(rand_index),
    .flush_req(flush_req), .flush_mode(flush_mode), .flush_asid(flush_asid),
    .flush_busy(flush_busy), .flush_done(flush_done)
  );

  typedef struct {
    int              port;
    logic            found;
    logic            multi;
    logic [IDXW-1:0] idx;
    logic [19:0]     pfn;
    logic [2:0]      c;
    logic            d;
    logic            v;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Replacement index reference: reloads on reset, then counts down modulo TLBNUM.
  logic [IDXW-1:0] model_r;
  always @(posedge clk) begin
    if (reset) model_r <= IDXW'(TLBNUM - 1);
    else       model_r <= IDXW'((int'(model_r) + TLBNUM - 1) % TLBNUM);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int p, input logic f, input logic m, input int ix,
                              input logic [19:0] pfn, input logic odd);
    exp_t e;
    e.port  = p;
    e.found = f;
    e.multi = m;
    e.idx   = f ? IDXW'(ix) : '0;
    e.pfn   = f ? pfn : '0;
    // Every write below uses c0=2,d0=0,v0=1 / c1=3,d1=1,v1=1.
    e.c     = f ? (odd ? 3'd3 : 3'd2) : 3'd0;
    e.d     = f ? odd : 1'b0;
    e.v     = f;
    return e;
  endfunction

  task automatic search(input string tag, input int p, input logic [18:0] vpn2,
                        input logic odd, input logic [7:0] asid, input exp_t e);
    exp_t g;
    s_vpn2[p*19 +: 19] = vpn2;
    s_odd_page[p]      = odd;
    s_asid[p*8 +: 8]   = asid;
    sb.push_back(e);
    step();
    g = sb.pop_front();
    chk({tag, "_found"}, 32'(s_found[g.port]), 32'(g.found));
    chk({tag, "_multi"}, 32'(s_multi[g.port]), 32'(g.multi));
    chk({tag, "_index"}, 32'(s_index[g.port*IDXW +: IDXW]), 32'(g.idx));
    chk({tag, "_pfn"}, 32'(s_pfn[g.port*20 +: 20]), 32'(g.pfn));
    chk({tag, "_cdv"}, 32'({s_c[g.port*3 +: 3], s_d[g.port], s_v[g.port]}),
        32'({g.c, g.d, g.v}));
  endtask

  task automatic drive_w(input logic rnd, input int idx, input logic [18:0] vpn2,
                         input logic [7:0] asid, input logic g,
                         input logic [19:0] p0, input logic [19:0] p1);
    we = 1'b1; w_random = rnd; w_index = IDXW'(idx);
    w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = p0; w_c0 = 3'd2; w_d0 = 1'b0; w_v0 = 1'b1;
    w_pfn1 = p1; w_c1 = 3'd3; w_d1 = 1'b1; w_v1 = 1'b1;
  endtask

  task automatic wr(input logic rnd, input int idx, input logic [18:0] vpn2,
                    input logic [7:0] asid, input logic g,
                    input logic [19:0] p0, input logic [19:0] p1);
    drive_w(rnd, idx, vpn2, asid, g, p0, p1);
    step();
    we = 1'b0;
  endtask

  task automatic read_e(input string tag, input int idx, input logic exp);
    r_index = IDXW'(idx);
    #1;
    chk(tag, 32'(r_e), 32'(exp));
  endtask

  initial begin
    int r0, busy_n, done_n, done_at;
    bit again;
    reset = 1'b1; s_vpn2 = '0; s_odd_page = '0; s_asid = '0;
    we = 1'b0; w_random = 1'b0; w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
    w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
    w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
    r_index = '0; flush_req = 1'b0; flush_mode = 1'b0; flush_asid = '0;
    step(); step();

    chk("rst_rand", 32'(rand_index), 32'(TLBNUM - 1));
    chk("rst_busy", 32'({flush_busy, flush_done}), 32'd0);
    chk("rst_sfound", 32'(s_found), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < TLBNUM; i++) begin
      r_index = IDXW'(i);
      step();
      chk($sformatf("rst_re%0d", i), 32'(r_e), 32'd0);
    end
    search("rst_srch", 0, 19'h12345, 1'b0, 8'h03, mk(0, 0, 0, 0, '0, 0));

    wr(0, 5, 19'h12345, 8'h03, 1'b0, 20'hAAAAA, 20'hBBBBB);
    search("hit_odd", 1, 19'h12345, 1'b1, 8'h03, mk(1, 1, 0, 5, 20'hBBBBB, 1));
    search("hit_even", 0, 19'h12345, 1'b0, 8'h03, mk(0, 1, 0, 5, 20'hAAAAA, 0));
    search("miss_asid", 1, 19'h12345, 1'b1, 8'h04, mk(1, 0, 0, 0, '0, 0));

    wr(0, 9, 19'h55555, 8'h11, 1'b1, 20'h99999, 20'h88888);
    wr(0, 2, 19'h55555, 8'h22, 1'b1, 20'h22222, 20'h33333);
    search("multi", 0, 19'h55555, 1'b0, 8'h99, mk(0, 1, 1, 2, 20'h22222, 0));

    // Search on the same edge as the write must still miss; the next one hits.
    drive_w(0, 6, 19'h77777, 8'h01, 1'b0, 20'h66666, 20'h67676);
    search("same_edge", 1, 19'h77777, 1'b0, 8'h01, mk(1, 0, 0, 0, '0, 0));
    we = 1'b0;
    search("after_wr", 1, 19'h77777, 1'b0, 8'h01, mk(1, 1, 0, 6, 20'h66666, 0));

    chk("rand_pre", 32'(rand_index), 32'(model_r));
    r0 = int'(model_r);
    wr(1, 0, 19'h0ABCD, 8'h44, 1'b0, 20'h44444, 20'h55555);
    for (int k = 1; k <= 20; k++) begin
      chk($sformatf("rand_seq%0d", k), 32'(rand_index), 32'((r0 - k + 2*TLBNUM) % TLBNUM));
      if (k < 20) step();
    end
    read_e("rand_re", r0, 1'b1);
    chk("rand_vpn2", 32'(r_vpn2), 32'h0ABCD);
    chk("rand_asid", 32'(r_asid), 32'h44);

    wr(0, 1, 19'h01001, 8'h07, 1'b0, 20'h10000, 20'h10001);
    wr(0, 2, 19'h01002, 8'h07, 1'b1, 20'h20000, 20'h20001);
    wr(0, 3, 19'h01003, 8'h08, 1'b0, 20'h30000, 20'h30001);
    flush_mode = 1'b1; flush_asid = 8'h07; flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (flush_busy) busy_n++;
      if (flush_done) begin done_n++; if (done_at < 0) done_at = i; end
      flush_req = (i == 3);
      flush_mode = (i == 3) ? 1'b0 : 1'b1;
      if (i == 5) drive_w(0, 1, 19'h01001, 8'h08, 1'b1, 20'h0, 20'h0);
      if (i == 6) we = 1'b0;
      step();
    end
    flush_req = 1'b0; flush_mode = 1'b1;
    chk("aflush_busy_n", 32'(busy_n), 32'd16);
    chk("aflush_done_n", 32'(done_n), 32'd1);
    chk("aflush_done_at", 32'(done_at), 32'd16);
    read_e("aflush_e1", 1, 1'b0);
    chk("aflush_asid1", 32'(r_asid), 32'h07);
    read_e("aflush_e2", 2, 1'b1);
    read_e("aflush_e3", 3, 1'b1);

    flush_mode = 1'b0; flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("rflush_busy_pre", 32'(flush_busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rflush_busy_post", 32'({flush_busy, flush_done}), 32'd0);
    done_n = 0; busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (flush_done) done_n++;
      if (flush_busy) busy_n++;
      step();
    end
    chk("rflush_no_done", 32'(done_n), 32'd0);
    chk("rflush_no_busy", 32'(busy_n), 32'd0);
    read_e("rflush_e2", 2, 1'b0);
    read_e("rflush_e3", 3, 1'b0);

    wr(0, 4, 19'h04004, 8'h01, 1'b1, 20'h40000, 20'h40001);
    read_e("pre_flush_e4", 4, 1'b1);
    flush_mode = 1'b0; flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    busy_n = 0; done_n = 0; again = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (flush_busy) busy_n++;
      if (flush_done) done_n++;
      if (flush_done && !again) begin flush_req = 1'b1; again = 1'b1; end
      else flush_req = 1'b0;
      step();
    end
    flush_req = 1'b0;
    chk("b2b_busy_n", 32'(busy_n), 32'd32);
    chk("b2b_done_n", 32'(done_n), 32'd2);
    read_e("b2b_e4", 4, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
